reg_file_mp: RTL

Parametrised multi-read-port register file for the MIPS decode stage. Successor to the fixed 32×32, 2-read, read-or-write register file. It adds:
- configurable width, depth and read-port count;
- hardwired-zero register 0;
- simultaneous read and write, with write-to-read bypass;
- a reset-driven clear sweep, with a `ready` indication while it runs.

Sits between instruction decode (register specifiers) and the execute-stage operand latches.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_rd_port.sv | 52 +++++
 rtl/reg_file_mp.sv | 113 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types, defaults and the address-width helper for the register file.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   localparam int unsigned DefaultDataW   = 32;
   localparam int unsigned DefaultNumRegs = 32;

   // Address width for n registers; never less than one bit.
   function automatic int unsigned addr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: range/zero check, write-to-read bypass and output register.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DefaultDataW,
   parameter int unsigned NUM_REGS = DefaultNumRegs,
   parameter int unsigned ADDR_W   = addr_width(NUM_REGS),
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_accept,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wr_ok,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

   logic              in_range;
   logic              is_zero;
   logic [DATA_W-1:0] rd_data_d;
   logic [DATA_W-1:0] rd_data_q;

   assign in_range = ({1'b0, rd_addr} < NumRegsW);
   assign is_zero  = (ZERO_REG != 0) && (rd_addr == '0);

   // Select read data: forced zero, then bypassed write data, then storage.
   always_comb begin
      rd_data_d = mem_data;
      if (!in_range || is_zero) begin
         rd_data_d = '0;
      end else if (wr_ok && (wr_addr == rd_addr)) begin
         rd_data_d = wr_data;
      end
   end

   // Output register holds its value when no read is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_accept) begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired zero, bypass and reset clear sweep.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int unsigned       DATA_W   = DefaultDataW,
   parameter int unsigned       NUM_REGS = DefaultNumRegs,
   parameter int unsigned       ADDR_W   = addr_width(NUM_REGS),
   parameter int unsigned       NUM_RD   = 2,
   parameter int unsigned       ZERO_REG = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   output logic                     ready
);

   localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LastReg  = ADDR_W'(NUM_REGS - 1);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              ready_q;
   logic              rd_valid_q;
   logic              run;
   logic              rd_accept;
   logic              wr_ok;
   logic [DATA_W-1:0] mem [NUM_REGS];

   assign run       = (state_q == RUN);
   assign rd_accept = run && rd_en;
   // A write is performed only in RUN, in range, and not aimed at a hardwired zero.
   assign wr_ok     = run && wr_en && ({1'b0, wr_addr} < NumRegsW) &&
                      !((ZERO_REG != 0) && (wr_addr == '0));

   // Clear sweep: walk every register once, then enter RUN.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LastReg) begin
               state_d   = RUN;
               clr_ptr_d = '0;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = CLEAR;
      endcase
   end

   // Control state; ready lags the state by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_ptr_q  <= '0;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         ready_q    <= run;
         rd_valid_q <= rd_accept;
      end
   end

   // Storage: sweep writes during CLEAR, user writes during RUN.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == CLEAR) begin
            mem[clr_ptr_q] <= INIT_VAL;
         end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] mem_data;

      assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
      assign mem_data = ({1'b0, addr} < NumRegsW) ? mem[addr] : '0;

      reg_file_rd_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .clk       (clk),
         .rst       (rst),
         .rd_accept (rd_accept),
         .rd_addr   (addr),
         .mem_data  (mem_data),
         .wr_ok     (wr_ok),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .rd_data   (rd_data[p*DATA_W +: DATA_W])
      );
   end

   assign rd_valid = rd_valid_q;
   assign ready    = ready_q;

endmodule
